// File: rtl/seq_divider.sv
// Sequential restoring divider, one shift-subtract step per clock.
// Define DIVIDER_SIGNED_EN for two's-complement truncating division.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_pend_q, dz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   a_sh, q_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   a_nx, q_nx;
  logic [WIDTH-1:0]   dd_mag, dv_mag;
  logic [WIDTH-1:0]   q_fix, r_fix, dz_rem;

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  // One restoring iteration on {A,Q}
  always_comb begin
    shifted = {a_q, q_q} << 1;
    a_sh    = shifted[2*WIDTH-1:WIDTH];
    q_sh    = shifted[WIDTH-1:0];
    trial   = {1'b0, a_sh} - {1'b0, m_q};
    if (!trial[WIDTH]) begin
      a_nx = trial[WIDTH-1:0];
      q_nx = {q_sh[WIDTH-1:1], 1'b1};
    end else begin
      a_nx = a_sh;
      q_nx = {q_sh[WIDTH-1:1], 1'b0};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  // Operand magnitudes in, sign-corrected results out
  always_comb begin
    dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
    q_fix  = qneg_q ? -q_nx : q_nx;
    r_fix  = rneg_q ? -a_nx : a_nx;
    dz_rem = rneg_q ? -q_q : q_q;
  end
`else
  // Unsigned: operands and results pass straight through
  always_comb begin
    dd_mag = dividend;
    dv_mag = divisor;
    q_fix  = q_nx;
    r_fix  = a_nx;
    dz_rem = q_q;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    count_d   = count_q;
    dz_pend_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (dz_pend_q) begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
          quot_d = '1;
          rem_d  = dz_rem;
        end
        if (start) begin
          a_d     = '0;
          q_d     = dd_mag;
          m_d     = dv_mag;
          count_d = CW'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            dz_pend_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        a_d     = a_nx;
        q_d     = q_nx;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          quot_d  = q_fix;
          rem_d   = r_fix;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      count_q   <= count_d;
      dz_pend_q <= dz_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse-operation partner of the 8-bit shift-add multiplier datapath. It divides an unsigned dividend by an unsigned divisor using one shift-subtract iteration per clock on a combined {remainder, quotient} shift register. It presents quotient, remainder and a divide-by-zero flag behind a start/busy/done handshake. It sits beside the multiplier in the arithmetic unit and shares its operand and result buses.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only while idle (busy=0)
- dividend  in  WIDTH  numerator, captured on the accepting edge
- divisor  in  WIDTH  denominator, captured on the accepting edge
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- quotient  out  WIDTH  result, held until the next accepted start
- remainder  out  WIDTH  result, held until the next accepted start
- div_by_zero  out  1  set with done when divisor was 0; held like results

## Operation
- Reset: every output is 0, the state is IDLE, and the iteration counter is 0.
- States: IDLE, RUN.
- IDLE with start=1: the block captures the operands into A=0, Q=dividend, M=divisor and sets count=WIDTH.
  - If divisor≠0: next state RUN, busy=1.
  - If divisor=0: no iteration. On the next edge, done=1, div_by_zero=1, quotient=all ones and remainder=dividend. The state stays IDLE.
- RUN, each edge:
  - Shift {A,Q} left by 1.
  - Compute trial = {1'b0,A_shifted} − {1'b0,M} at WIDTH+1 bits.
  - If trial is non-negative: A=trial[WIDTH-1:0] and Q[0]=1. Otherwise A is kept and Q[0]=0.
  - Decrement count.
- Final iteration (count 1→0): quotient=Q, remainder=A, done=1, busy=0, div_by_zero=0, state returns to IDLE. All of this happens on the same edge.
- Invariant: remainder < divisor, and quotient·divisor + remainder = dividend (unsigned, WIDTH bits).
- start while busy=1 is ignored; no queueing.
- rst=1 mid-RUN aborts the operation: no done is produced and all outputs clear.

## Timing
- Accepting edge E0 (start=1, busy=0). busy is high after E0 through EWIDTH.
- done is high for exactly the one cycle after EWIDTH, so results are visible WIDTH cycles after the accepting edge (8 for WIDTH=8).
- Divide-by-zero: done is high in the cycle after E1, a latency of 1.
- A start asserted during the done cycle is accepted at that edge, giving back-to-back operation with no idle gap.
- The results registers change only at a done edge or at reset. Between done pulses they are stable.
- There is no combinational path from inputs to outputs.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - dividend and divisor are two's complement.
  - The core divides the magnitudes.
  - quotient is negated when the operand signs differ.
  - remainder takes the dividend's sign (truncating division).
  - Sign correction is applied on the final edge, so latency is unchanged.
  - The most-negative value ÷ −1 yields quotient=most-negative (wrap) and remainder=0.
  - Divide-by-zero gives quotient=all ones and remainder=dividend.
- DIVIDER_SIGNED_EN undefined: purely unsigned, exactly as described above. No sign logic is synthesized.

## Test plan
- 200÷7: done exactly 8 cycles after the accepting edge; quotient=28, remainder=4, div_by_zero=0; busy high for 8 cycles.
- Boundaries:
  - 255÷1 → 255 r 0.
  - 5÷9 → 0 r 5.
  - 255÷255 → 1 r 0.
  - 0÷3 → 0 r 0.
- 77÷0: done one cycle after the accepting edge; quotient=0xFF, remainder=77, div_by_zero=1, busy never high.
- Sequencing:
  - Start 100÷3, then pulse start again with 50÷5 two cycles later: the second request is ignored and the result is 33 r 1.
  - Start during the done cycle with 50÷5: accepted, and the result is 10 r 0 eight cycles later.
- Reset mid-operation: start 200÷7, assert rst on cycle 4. All outputs are 0 and no done appears. A later start of 9÷2 gives 4 r 1.
- With DIVIDER_SIGNED_EN:
  - −100÷7 → quotient 0xF2 (−14), remainder 0xFE (−2).
  - −128÷−1 → quotient 0x80, remainder 0.
